to_affine: RTL
==============

Name: to_affine

Overview:
- Initiator side of the field-inversion interface in the scalar-multiplication datapath.
- Converts a projective X-coordinate result (X, Z) to affine x = X·Z⁻¹ mod p, where p = 2^255−19.
- Drives the inverter's operand port and detects a change on it to request an inversion, then collects the inverse.
- Multiplies X by the inverse with an internal bit-serial interleaved modular multiplier.

Parameters:
- P_255, 2^255−19, field prime (255 bits).
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for the inverter's valid before flagging an error.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- x_in  input  255  projective X, any value below 2^255.
- z_in  input  255  projective Z, any value below 2^255.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; Z ≡ 0 mod p or inverter timeout.
- x_out  output  255  affine x, fully reduced (< p); held until the next done.
- inv_a  output  255  operand to the inverter; the inverter starts a computation whenever this value changes.
- inv_result  input  255  inverse from the inverter.
- inv_valid  input  1  inverter result valid.

Behaviour:
- Reset values: busy=0, done=0, err=0, x_out=0, inv_a=0, cache_ok=0, state=IDLE, timeout counter=0.
- rst mid-operation aborts everything on the next edge; inv_a returns to 0.
- States: IDLE, REDUCE, CHECK, WAIT_LOW, WAIT_HIGH, MUL, FIN.
- IDLE: on start, latch x_in and z_in and go to REDUCE. start while busy is ignored.
- REDUCE (1 cycle): replace any operand ≥ p with operand − p. One subtraction is enough because 2^255−1 < 2p.
- CHECK:
  - If Z = 0: set err, force x_out = 0, go to FIN. inv_a is not driven, because the inverter never terminates on 0.
  - Else if cache_ok and Z = inv_a: reuse the stored inverse, go to MUL. The inverter does not restart on an unchanged operand.
  - Else: drive inv_a ← Z, clear cache_ok and the timeout counter, go to WAIT_LOW.
- WAIT_LOW: wait for inv_valid = 0. The inverter's valid from a previous result stays high for up to 2 cycles after the operand changes.
- WAIT_HIGH: on inv_valid = 1, store inv_result, set cache_ok, go to MUL.
- Timeout: the counter runs through WAIT_LOW and WAIT_HIGH. At TIMEOUT_CYCLES: set err, x_out = 0, cache_ok = 0, go to FIN.
- MUL: MSB-first interleaved multiply of X by the inverse, one multiplier bit per cycle, 255 cycles.
  - Initialise acc = 0, counter i = 254.
  - Each cycle: t = 2·acc; if t ≥ p then t −= p; if bit i of the inverse is set, t += X, and if t ≥ p then t −= p; acc = t.
  - Internal width is 257 bits; acc < p holds after every step.
  - After i = 0: x_out ← acc, err = 0, go to FIN.
- FIN: done = 1 and busy = 0 for exactly this cycle, then IDLE. A start in the same cycle is ignored; start is accepted from IDLE only.
- Latency, start to done, excluding inverter time: 1 (REDUCE) + 1 (CHECK) + 255 (MUL) + 1 (FIN), plus at least 2 cycles of handshake when the inverter is used.
- inv_a holds its value between operations; it changes only in CHECK.

Test Plan:
- Bench instantiates the real inverter on inv_a, inv_result and inv_valid.
- X=5, Z=1 → x_out=5, err=0, done pulses once; inv_a=1.
- X=1, Z=2 → x_out=2^254−9 (that is, (p+1)/2), err=0.
- Repeat X=3, Z=2 immediately after the previous case → inv_a unchanged, no wait states, done exactly 258 cycles after start, x_out=2^254−8.
- Z=0, and separately Z=p (reduces to 0) → err=1, x_out=0, done 3 cycles after start, inv_a not modified.
- Stub inverter holding inv_valid=0, X=7, Z=9 → err=1 and done after TIMEOUT_CYCLES; a following start with the same Z re-enters WAIT_LOW (cache not used).
- Assert rst during MUL → next cycle busy=0, done=0, x_out=0, inv_a=0; a fresh X=5, Z=1 then yields x_out=5.

Source files
------------

// File: rtl/to_affine.sv
// Projective-to-affine conversion x = X * Z^-1 mod (2^255 - 19).
// Drives an external inverter through its operand port and multiplies with a bit-serial interleaved multiplier.
module to_affine #(
   parameter logic [254:0] P_255          = 255'((256'd1 << 255) - 256'd19),
   parameter int unsigned  TIMEOUT_CYCLES = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [254:0] x_in,
   input  logic [254:0] z_in,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [254:0] x_out,
   output logic [254:0] inv_a,
   input  logic [254:0] inv_result,
   input  logic         inv_valid
);
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [256:0] P_W = {2'b00, P_255};

   typedef enum logic [2:0] {
      IDLE, REDUCE, CHECK, WAIT_LOW, WAIT_HIGH, MUL, FIN
   } state_t;

   state_t        state_q, state_d;
   logic [254:0]  x_q, x_d, z_q, z_d, inv_q, inv_d;
   logic [254:0]  x_out_q, x_out_d, inv_a_q, inv_a_d;
   logic [256:0]  acc_q, acc_d;
   logic [7:0]    i_q, i_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cache_ok_q, cache_ok_d, err_q, err_d;

   logic [256:0]  t_dbl, t_red, t_add, acc_step;
   logic          timeout;

   // One multiplier bit per cycle; acc stays below p after each step.
   always_comb begin
      t_dbl    = acc_q << 1;
      t_red    = (t_dbl >= P_W) ? t_dbl - P_W : t_dbl;
      t_add    = inv_q[i_q] ? t_red + {2'b00, x_q} : t_red;
      acc_step = (t_add >= P_W) ? t_add - P_W : t_add;
   end

   assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      z_d        = z_q;
      inv_d      = inv_q;
      acc_d      = acc_q;
      i_d        = i_q;
      cnt_d      = cnt_q;
      cache_ok_d = cache_ok_q;
      err_d      = err_q;
      x_out_d    = x_out_q;
      inv_a_d    = inv_a_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = x_in;
               z_d     = z_in;
               state_d = REDUCE;
            end
         end
         REDUCE: begin
            if (x_q >= P_255) x_d = x_q - P_255;
            if (z_q >= P_255) z_d = z_q - P_255;
            state_d = CHECK;
         end
         CHECK: begin
            acc_d = '0;
            i_d   = 8'd254;
            // Z = 0 never reaches the inverter: it would not terminate.
            if (z_q == '0) begin
               err_d   = 1'b1;
               x_out_d = '0;
               state_d = FIN;
            end else if (cache_ok_q && (z_q == inv_a_q)) begin
               state_d = MUL;
            end else begin
               inv_a_d    = z_q;
               cache_ok_d = 1'b0;
               cnt_d      = '0;
               state_d    = WAIT_LOW;
            end
         end
         WAIT_LOW, WAIT_HIGH: begin
            if (timeout) begin
               err_d      = 1'b1;
               x_out_d    = '0;
               cache_ok_d = 1'b0;
               state_d    = FIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (state_q == WAIT_LOW) begin
                  if (!inv_valid) state_d = WAIT_HIGH;
               end else if (inv_valid) begin
                  inv_d      = inv_result;
                  cache_ok_d = 1'b1;
                  state_d    = MUL;
               end
            end
         end
         MUL: begin
            acc_d = acc_step;
            i_d   = i_q - 8'd1;
            if (i_q == 8'd0) begin
               x_out_d = acc_step[254:0];
               err_d   = 1'b0;
               state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= '0;
         z_q        <= '0;
         inv_q      <= '0;
         acc_q      <= '0;
         i_q        <= '0;
         cnt_q      <= '0;
         cache_ok_q <= 1'b0;
         err_q      <= 1'b0;
         x_out_q    <= '0;
         inv_a_q    <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         z_q        <= z_d;
         inv_q      <= inv_d;
         acc_q      <= acc_d;
         i_q        <= i_d;
         cnt_q      <= cnt_d;
         cache_ok_q <= cache_ok_d;
         err_q      <= err_d;
         x_out_q    <= x_out_d;
         inv_a_q    <= inv_a_d;
      end
   end

   assign busy  = (state_q != IDLE) && (state_q != FIN);
   assign done  = (state_q == FIN);
   assign err   = err_q;
   assign x_out = x_out_q;
   assign inv_a = inv_a_q;
endmodule
